// File: rtl/tone_synth.sv
// Multi-channel tone source: per-channel phase accumulators advanced by a
// sample-rate divider, shaped into silence/square/saw/triangle and amplitude scaled.
module tone_synth #(
  parameter int NUM_CH  = 2,
  parameter int DATA_W  = 16,
  parameter int PHASE_W = 24,
  parameter int DIV_W   = 16
) (
  input  logic                      clk,
  input  logic                      aclr,
  input  logic                      enable,
  input  logic [DIV_W-1:0]          sample_div,
  input  logic                      phase_clr,
  input  logic [NUM_CH*PHASE_W-1:0] phase_inc,
  input  logic [NUM_CH*2-1:0]       mode,
  input  logic [NUM_CH*8-1:0]       amp,
  input  logic                      fifo_full,
  input  logic                      overrun_clr,
  output logic                      tone_pcm_rdy,
  output logic [NUM_CH*DATA_W-1:0]  tone_pcm,
  output logic                      overrun
);

  // Write handshake: a sample is offered whenever pending_q is set; it is
  // accepted in any cycle where fifo_full is low at the clock edge, and the
  // accepted word appears on tone_pcm together with a one-cycle tone_pcm_rdy.

  logic [DIV_W-1:0]          div_cnt_q, div_cnt_d;
  logic [NUM_CH*PHASE_W-1:0] phase_q, phase_d;
  logic                      pending_q, pending_d;
  logic                      overrun_q, overrun_d;
  logic                      tone_pcm_rdy_q, tone_pcm_rdy_d;
  logic [NUM_CH*DATA_W-1:0]  tone_pcm_q, tone_pcm_d;
  logic                      tick;
  logic                      write_en;

  function automatic logic [DATA_W-1:0] shape(input logic [DATA_W-1:0] p,
                                              input logic [1:0]        md,
                                              input logic [7:0]        a);
    logic [DATA_W-1:0]        wave;
    logic [DATA_W-1:0]        q;
    logic signed [DATA_W+8:0] wave_x;
    logic signed [DATA_W+8:0] amp_x;
    logic signed [DATA_W+8:0] prod;
    q = {p[DATA_W-2:0], 1'b0};
    if (p[DATA_W-1]) q = ~q;
    case (md)
      2'd0:    wave = '0;
      2'd1:    wave = p[DATA_W-1] ? {1'b1, {(DATA_W-1){1'b0}}} : {1'b0, {(DATA_W-1){1'b1}}};
      2'd2:    wave = {~p[DATA_W-1], p[DATA_W-2:0]};
      default: wave = {~q[DATA_W-1], q[DATA_W-2:0]};
    endcase
    wave_x = {{9{wave[DATA_W-1]}}, wave};
    amp_x  = {{(DATA_W+1){1'b0}}, a};
    prod   = wave_x * amp_x;
    prod   = prod >>> 8;
    return prod[DATA_W-1:0];
  endfunction

  always_comb begin
    tick           = enable && (div_cnt_q == sample_div);
    write_en       = pending_q && !fifo_full;
    div_cnt_d      = (!enable || tick) ? '0 : div_cnt_q + DIV_W'(1);
    phase_d        = phase_q;
    tone_pcm_d     = tone_pcm_q;
    tone_pcm_rdy_d = write_en;
    pending_d      = pending_q;
    overrun_d      = overrun_q;

    // The write samples the pre-tick phase, so a coincident tick just re-arms pending.
    for (int c = 0; c < NUM_CH; c++) begin
      if (phase_clr)
        phase_d[c*PHASE_W +: PHASE_W] = '0;
      else if (tick)
        phase_d[c*PHASE_W +: PHASE_W] = phase_q[c*PHASE_W +: PHASE_W] + phase_inc[c*PHASE_W +: PHASE_W];
      if (write_en)
        tone_pcm_d[c*DATA_W +: DATA_W] = shape(phase_q[c*PHASE_W+PHASE_W-1 -: DATA_W],
                                               mode[c*2 +: 2], amp[c*8 +: 8]);
    end

    if (phase_clr)     pending_d = 1'b0;
    else if (tick)     pending_d = 1'b1;
    else if (write_en) pending_d = 1'b0;

    if (tick && pending_q && !write_en && !phase_clr) overrun_d = 1'b1;
    else if (overrun_clr)                             overrun_d = 1'b0;
  end

  always_ff @(posedge clk or negedge aclr) begin
    if (!aclr) begin
      div_cnt_q      <= '0;
      phase_q        <= '0;
      pending_q      <= 1'b0;
      overrun_q      <= 1'b0;
      tone_pcm_rdy_q <= 1'b0;
      tone_pcm_q     <= '0;
    end else begin
      div_cnt_q      <= div_cnt_d;
      phase_q        <= phase_d;
      pending_q      <= pending_d;
      overrun_q      <= overrun_d;
      tone_pcm_rdy_q <= tone_pcm_rdy_d;
      tone_pcm_q     <= tone_pcm_d;
    end
  end

  assign tone_pcm_rdy = tone_pcm_rdy_q;
  assign tone_pcm     = tone_pcm_q;
  assign overrun      = overrun_q;

endmodule

// File: doc/tone_synth.md
# tone_synth

Parametrised multi-channel tone source for the audio path. Each channel runs a phase accumulator clocked by a programmable sample-rate divider and produces a silence, square, sawtooth or triangle wave, scaled by an 8-bit amplitude. One packed signed PCM word per sample period is pushed into the downstream sample FIFO through the same `fifo_full` / `tone_pcm_rdy` write handshake the audio FIFO already uses. Sample-period overruns caused by FIFO back-pressure are flagged.

## Interface
- `NUM_CH`, 2: number of channels. Channel 0 is in the LSBs of every packed bus.
- `DATA_W`, 16: PCM sample width per channel, signed two's complement. Range ≥ 4.
- `PHASE_W`, 24: phase accumulator width. Must be ≥ `DATA_W`.
- `DIV_W`, 16: sample divider counter width.

Ports:
- `clk`  in  1  system clock.
- `aclr`  in  1  reset, asynchronous, active-low.
- `enable`  in  1  high runs the divider; low holds the divider at 0, so no ticks occur.
- `sample_div`  in  DIV_W  clocks per sample period minus 1. A value of 0 gives a tick every cycle.
- `phase_clr`  in  1  synchronous pulse that zeroes all accumulators and clears `pending`.
- `phase_inc`  in  NUM_CH*PHASE_W  per-channel phase increment.
- `mode`  in  NUM_CH*2  per-channel wave select: 0 silence, 1 square, 2 saw, 3 triangle.
- `amp`  in  NUM_CH*8  per-channel unsigned amplitude.
- `fifo_full`  in  1  downstream FIFO full.
- `overrun_clr`  in  1  synchronous clear of `overrun`.
- `tone_pcm_rdy`  out  1  one-cycle write strobe.
- `tone_pcm`  out  NUM_CH*DATA_W  packed samples, valid when `tone_pcm_rdy` is high.
- `overrun`  out  1  sticky flag: a tick occurred while a sample was still pending.

## Operation
- **Divider.** The counter `div_cnt` counts 0..`sample_div`.
  - `tick` is high when `enable` is high and `div_cnt == sample_div`; the counter then wraps to 0.
  - If `sample_div` changes to a value below the current count, the counter wraps through 2^DIV_W (no special handling).
- **On tick:**
  - Each channel updates `phase[c] <= phase[c] + phase_inc[c]`, modulo 2^PHASE_W.
  - `pending` is set to 1.
- **Write.** When `pending` is 1 and `fifo_full` is 0:
  - `tone_pcm` is registered from the current phase registers, then `tone_pcm_rdy` goes to 1 for one cycle.
  - `pending` clears, unless a tick occurs in the same cycle (see Timing).
- **Back-pressure.** When `pending` is 1 and `fifo_full` is 1, nothing is written and `pending` holds. `tone_pcm` holds its last value.
- **Overrun.** A tick while `pending` is 1 and no write happens in that cycle sets `overrun`.
  - Phases still advance, so the next write reflects the newest phase; the stale sample is dropped.
  - `overrun_clr` clears the flag. A set condition in the same cycle wins over the clear.
- **`phase_clr`.** Has priority over a tick in the same cycle: phases become 0 and `pending` becomes 0.
- **Waveform (per channel).** Let `p` = `phase[PHASE_W-1 -: DATA_W]` and `M` = 2^(DATA_W-1).
  - Silence: 0.
  - Square: `p` MSB = 0 gives M-1, otherwise -M.
  - Saw: `p` with its MSB inverted, interpreted as signed.
  - Triangle: `q = {p[DATA_W-2:0], 1'b0}`; if `p` MSB = 1 then `q = ~q`; result = `q` with its MSB inverted, interpreted as signed.
- **Scaling.** `s = (wave * {1'b0, amp}) >>> 8`, computed signed at DATA_W+9 bits and truncated to DATA_W bits (it cannot overflow).
- **Sampling of controls.** `mode` and `amp` are sampled in the write cycle. `phase_inc` is sampled in the tick cycle.

## Timing
- **Reset values:** `tone_pcm_rdy` 0, `tone_pcm` 0, `overrun` 0, all phases 0, `pending` 0, `div_cnt` 0.
- **First tick** occurs on the (`sample_div`+1)-th rising edge after `aclr` deasserts with `enable` high.
- **Latency:** the write strobe is registered one cycle after the tick when `fifo_full` is low.
- **Write rate:** with no back-pressure, exactly one write per `sample_div`+1 cycles.
- **Tick and write in the same cycle** (`pending` set, FIFO not full):
  - The write uses the pre-tick phase.
  - The phase advances and `pending` stays 1.
  - No overrun is flagged.
- **`sample_div` = 0:** a tick every cycle gives a write every cycle, matching the FIFO's full-rate acceptance.
- **`fifo_full` rising in the write cycle:** the write proceeds only if `fifo_full` was 0 at that edge.
- **Reset mid-operation** clears everything immediately (asynchronously). A pending sample is discarded.

## Test plan
- **Reset and first tick.** NUM_CH=2, DATA_W=16, PHASE_W=24, `sample_div`=3, `phase_inc`=0x100000 on both channels, mode=2, amp=0 → all outputs 0; `tone_pcm_rdy` pulses every 4 cycles; `tone_pcm`=0 (amp 0).
- **Sawtooth.** `sample_div`=3, `phase_inc`=0x400000, mode=2, amp=128 → successive writes of `p` = 0x4000, 0x8000, 0xC000, 0x0000 give channel 0 = 0xE000, 0x0000, 0x2000, 0xC000 (for example 0x4000 → -0x4000 → >>>1 → 0xE000).
- **Square and triangle.** Mode 1, amp=255, `p`=0x4000 → 0x7F7F (32767*255>>>8); mode 3 at `p`=0x8000 → 0x7F7F.
- **Back-pressure.** Hold `fifo_full`=1 for 10 cycles with `sample_div`=3 → no strobes and `overrun`=1; release → one strobe next cycle carrying the latest phase; `overrun` stays 1 until `overrun_clr`.
- **`sample_div`=0 full rate.** → `tone_pcm_rdy` high every cycle after the first tick; `overrun` stays 0.
- **Mid-run disturbances.** `phase_clr` coincident with a tick → phases 0 and no strobe on the next cycle. `aclr` pulse mid-run → all outputs 0 within the same cycle.
